commit_trace_packer: RTL and testbench
======================================

COMMIT_TRACE_PACKER -- requirements
Module: commit_trace_packer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO depth in records (power of two, >=4).
REQ-002 SHALL have port clk_i  input  1  core clock; all state on rising edge.
REQ-003 SHALL have port rst_i  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have port enable_i  input  1  capture enable.
REQ-005 SHALL have port commit_ack_i  input  2  per-port commit strobe; port 0 older than port 1.
REQ-006 SHALL have port commit_pc_i  input  2x64  committed PC per port.
REQ-007 SHALL have port commit_instr_i  input  2x32  committed instruction word per port.
REQ-008 SHALL have port commit_waddr_i  input  2x5  destination register per port.
REQ-009 SHALL have port commit_wdata_i  input  2x64  writeback data per port.
REQ-010 SHALL have ports commit_we_gpr_i, commit_we_fpr_i, commit_we_posr_i  input  2 each  register-file write enables per port.
REQ-011 SHALL have port commit_ex_i  input  2  instruction raised an exception, per port.
REQ-012 SHALL have port priv_lvl_i  input  2  current privilege level, shared by both ports.
REQ-013 SHALL have port debug_mode_i  input  1  core in debug mode.
REQ-014 SHALL have port trace_valid_o  output  1  record available.
REQ-015 SHALL have port trace_ready_i  input  1  sink accepts record.
REQ-016 SHALL have port trace_data_o  output  179  record: [178:115] pc, [114:83] instr, [82:19] wdata, [18:14] waddr, [13:12] rf, [11] ex, [10:9] priv, [8] debug, [7:0] seq.
REQ-017 SHALL have port level_o  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-018 SHALL have port drop_cnt_o  output  16  records lost to overflow, saturating.

Function
REQ-019 SHALL set rf to 01 if we_gpr, else 10 if we_fpr, else 11 if we_posr, else 00.
REQ-020 SHALL process a port only when enable_i=1 and its commit_ack_i bit=1.
REQ-021 SHALL enqueue port 0 before port 1 in the same cycle; a lone ack[1] SHALL be processed as a single record.
REQ-022 SHALL compute free = DEPTH - level_o from registered state, giving no credit for a same-cycle pop.
REQ-023 SHALL enqueue processed records in order while free allows; remaining records SHALL be dropped.
REQ-024 SHALL add the number dropped (0..2) to drop_cnt_o, saturating at 0xFFFF.
REQ-025 SHALL keep an 8-bit seq counter, incremented once per processed record, whether enqueued or dropped, wrapping 255->0.
REQ-026 SHALL stamp each record with the seq value before its own increment (port 0 gets seq, port 1 gets seq+1).
REQ-027 SHALL drive trace_valid_o = (level_o != 0) and trace_data_o = head record, both from registered state.
REQ-028 SHALL pop the head when trace_valid_o && trace_ready_i.
REQ-029 SHALL hold trace_data_o stable while trace_valid_o=1 and trace_ready_i=0.
REQ-030 SHALL make a record committed in cycle N visible at the output in cycle N+1 at the earliest.
REQ-031 SHALL update level_o by (+pushes - pop) per cycle, so simultaneous push and pop leave the level correct; pointers SHALL wrap modulo DEPTH.
REQ-032 SHALL continue to drain the FIFO while enable_i=0; enable_i=0 SHALL freeze seq and drop_cnt_o.

Reset
REQ-033 SHALL, on rst_i=1, immediately clear level_o, pointers, seq and drop_cnt_o to 0 and drive trace_valid_o=0; FIFO contents are don't-care.
REQ-034 SHALL discard all buffered records on reset mid-operation; first record after release SHALL carry seq 0.

Verification
REQ-035 Single commit: ack=01, pc=0x80000000, we_gpr=01, waddr=5 -> next cycle valid=1, pc=0x80000000, rf=01, waddr=5, seq=0.
REQ-036 Dual commit, ready=1: ack=11, pcs 0x100/0x104 -> records 0x100 (seq 0) then 0x104 (seq 1) on consecutive cycles.
REQ-037 Overflow: ready=0, DEPTH=8, four cycles of ack=11, then one more ack=11 -> level_o=8, drop_cnt_o=2, next record after draining 8 has seq 10.
REQ-038 Backpressure: ready toggles 0/1 every cycle for 6 records -> data stable while stalled, order and seq contiguous, no loss.
REQ-039 Saturation: force 0xFFFF drops -> drop_cnt_o holds 0xFFFF on further drops.
REQ-040 Reset mid-stream: rst_i asserted with level_o=5 -> valid=0 and level_o=0 asynchronously; next commit after release yields seq 0.

Source files
------------

// File: rtl/commit_trace_packer.sv
// Commit trace packer: turns up to two retired instructions per cycle into
// 179-bit trace records, stamps them with a sequence number and buffers them
// in a small FIFO for a ready/valid sink. Records that do not fit are counted
// in a saturating drop counter.
module commit_trace_packer #(
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     enable_i,
  input  logic [1:0]               commit_ack_i,
  input  logic [1:0][63:0]         commit_pc_i,
  input  logic [1:0][31:0]         commit_instr_i,
  input  logic [1:0][4:0]          commit_waddr_i,
  input  logic [1:0][63:0]         commit_wdata_i,
  input  logic [1:0]               commit_we_gpr_i,
  input  logic [1:0]               commit_we_fpr_i,
  input  logic [1:0]               commit_we_posr_i,
  input  logic [1:0]               commit_ex_i,
  input  logic [1:0]               priv_lvl_i,
  input  logic                     debug_mode_i,
  output logic                     trace_valid_o,
  input  logic                     trace_ready_i,
  output logic [178:0]             trace_data_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic [15:0]              drop_cnt_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  // Register-file tag: GPR wins over FPR, FPR over POSR.
  function automatic logic [1:0] rf_enc(input logic gpr, input logic fpr, input logic posr);
    logic [1:0] rf;
    if (gpr) begin
      rf = 2'b01;
    end else if (fpr) begin
      rf = 2'b10;
    end else if (posr) begin
      rf = 2'b11;
    end else begin
      rf = 2'b00;
    end
    return rf;
  endfunction

  logic [178:0]   mem_q [DEPTH];
  logic [PW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LW-1:0]  level_q, level_d;
  logic [7:0]     seq_q, seq_d;
  logic [15:0]    drop_q, drop_d;

  logic [1:0]     proc_s;
  logic [1:0]     n_proc_s, n_push_s, n_drop_s;
  logic [LW-1:0]  free_s;
  logic           pop_s;
  logic [7:0]     seq1_s;
  logic [178:0]   rec0_s, rec1_s, first_s, second_s;
  logic [16:0]    drop_sum_s;
  logic [PW-1:0]  wptr1_s;

  // Record formatting, admission against registered free space, and next state.
  always_comb begin
    proc_s   = enable_i ? commit_ack_i : 2'b00;
    n_proc_s = {1'b0, proc_s[0]} + {1'b0, proc_s[1]};
    // Port 1 takes seq+1 only when port 0 also consumed a number this cycle.
    seq1_s   = proc_s[0] ? (seq_q + 8'd1) : seq_q;
    rec0_s   = {commit_pc_i[0], commit_instr_i[0], commit_wdata_i[0], commit_waddr_i[0],
                rf_enc(commit_we_gpr_i[0], commit_we_fpr_i[0], commit_we_posr_i[0]),
                commit_ex_i[0], priv_lvl_i, debug_mode_i, seq_q};
    rec1_s   = {commit_pc_i[1], commit_instr_i[1], commit_wdata_i[1], commit_waddr_i[1],
                rf_enc(commit_we_gpr_i[1], commit_we_fpr_i[1], commit_we_posr_i[1]),
                commit_ex_i[1], priv_lvl_i, debug_mode_i, seq1_s};
    first_s  = proc_s[0] ? rec0_s : rec1_s;
    second_s = rec1_s;

    // A pop in this cycle does not make room for this cycle's pushes.
    free_s = LW'(DEPTH) - level_q;
    if ({{(LW-2){1'b0}}, n_proc_s} <= free_s) begin
      n_push_s = n_proc_s;
    end else begin
      n_push_s = free_s[1:0];
    end
    n_drop_s = n_proc_s - n_push_s;

    pop_s   = (level_q != {LW{1'b0}}) && trace_ready_i;
    level_d = level_q + {{(LW-2){1'b0}}, n_push_s} - {{(LW-1){1'b0}}, pop_s};
    wptr_d  = wptr_q + {{(PW-2){1'b0}}, n_push_s};
    rptr_d  = rptr_q + {{(PW-1){1'b0}}, pop_s};
    wptr1_s = wptr_q + {{(PW-1){1'b0}}, 1'b1};

    drop_sum_s = {1'b0, drop_q} + {15'd0, n_drop_s};
    if (drop_sum_s[16]) begin
      drop_d = 16'hFFFF;
    end else begin
      drop_d = drop_sum_s[15:0];
    end
    seq_d = seq_q + {6'd0, n_proc_s};
  end

  // Control state: pointers, occupancy, sequence and drop counters.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= {PW{1'b0}};
      rptr_q  <= {PW{1'b0}};
      level_q <= {LW{1'b0}};
      seq_q   <= 8'd0;
      drop_q  <= 16'd0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      seq_q   <= seq_d;
      drop_q  <= drop_d;
    end
  end

  // Record storage; contents are irrelevant after reset so no reset here.
  always_ff @(posedge clk_i) begin
    if (n_push_s != 2'd0) begin
      mem_q[wptr_q] <= first_s;
    end
    if (n_push_s == 2'd2) begin
      mem_q[wptr1_s] <= second_s;
    end
  end

  assign trace_valid_o = (level_q != {LW{1'b0}});
  assign trace_data_o  = mem_q[rptr_q];
  assign level_o       = level_q;
  assign drop_cnt_o    = drop_q;

endmodule

// File: tb/tb_commit_trace_packer.sv
// Self-checking bench for commit_trace_packer (DEPTH=8) with a queue scoreboard.
module tb_commit_trace_packer;

  localparam int DEPTH = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              enable;
  logic [1:0]        ack;
  logic [1:0][63:0]  pc;
  logic [1:0][31:0]  instr;
  logic [1:0][4:0]   waddr;
  logic [1:0][63:0]  wdata;
  logic [1:0]        we_gpr, we_fpr, we_posr, ex;
  logic [1:0]        priv;
  logic              dbg;
  logic              valid;
  logic              ready;
  logic [178:0]      data;
  logic [3:0]        level;
  logic [15:0]       drop;

  int vectors = 0;
  int miscompares = 0;
  logic [178:0] sb_q[$];
  logic [7:0]   m_seq;
  int           m_drop;

  commit_trace_packer #(.DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .commit_ack_i(ack),
    .commit_pc_i(pc), .commit_instr_i(instr), .commit_waddr_i(waddr),
    .commit_wdata_i(wdata), .commit_we_gpr_i(we_gpr), .commit_we_fpr_i(we_fpr),
    .commit_we_posr_i(we_posr), .commit_ex_i(ex), .priv_lvl_i(priv),
    .debug_mode_i(dbg), .trace_valid_o(valid), .trace_ready_i(ready),
    .trace_data_o(data), .level_o(level), .drop_cnt_o(drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [178:0] got, input logic [178:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] rf_of(input logic g, input logic f, input logic p);
    if (g) return 2'b01;
    if (f) return 2'b10;
    if (p) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [178:0] mk(input int p, input logic [7:0] s);
    return {pc[p], instr[p], wdata[p], waddr[p], rf_of(we_gpr[p], we_fpr[p], we_posr[p]),
            ex[p], priv, dbg, s};
  endfunction

  task automatic rand_ports();
    for (int p = 0; p < 2; p++) begin
      pc[p]    = {$urandom, $urandom};
      instr[p] = $urandom;
      wdata[p] = {$urandom, $urandom};
      waddr[p] = 5'($urandom_range(0, 31));
    end
    we_gpr  = 2'($urandom_range(0, 3));
    we_fpr  = 2'($urandom_range(0, 3));
    we_posr = 2'($urandom_range(0, 3));
    ex      = 2'($urandom_range(0, 3));
    priv    = 2'($urandom_range(0, 3));
    dbg     = 1'($urandom_range(0, 1));
  endtask

  // Check outputs for the current cycle, advance the model across the next edge.
  task automatic cycle();
    int free;
    chk("valid", {178'd0, valid}, {178'd0, (sb_q.size() != 0)});
    chk("level", {175'd0, level}, 179'(sb_q.size()));
    chk("drop", {163'd0, drop}, 179'(m_drop));
    if (sb_q.size() != 0) chk("data", data, sb_q[0]);
    free = DEPTH - sb_q.size();
    if (ready && sb_q.size() != 0) void'(sb_q.pop_front());
    for (int p = 0; p < 2; p++) begin
      if (enable && ack[p]) begin
        if (free > 0) begin
          sb_q.push_back(mk(p, m_seq));
          free--;
        end else if (m_drop < 65535) begin
          m_drop++;
        end
        m_seq++;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; ack = 2'b00; ready = 1'b0;
    rand_ports();
    m_seq = 8'd0; m_drop = 0;
    @(negedge clk); @(negedge clk);
    chk("rst_valid", {178'd0, valid}, 179'd0);
    chk("rst_level", {175'd0, level}, 179'd0);
    chk("rst_drop", {163'd0, drop}, 179'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single commit on port 0.
    ready = 1'b1; ack = 2'b01;
    pc[0] = 64'h8000_0000; we_gpr = 2'b01; we_fpr = 2'b00; we_posr = 2'b00; waddr[0] = 5'd5;
    cycle();
    ack = 2'b00;
    chk("single_pc", {115'd0, data[178:115]}, 179'h8000_0000);
    chk("single_rf", {177'd0, data[13:12]}, 179'd1);
    chk("single_waddr", {174'd0, data[18:14]}, 179'd5);
    chk("single_seq", {171'd0, data[7:0]}, 179'd0);
    cycle();

    // Dual commit, port 0 first.
    ack = 2'b11; pc[0] = 64'h100; pc[1] = 64'h104;
    cycle();
    ack = 2'b00;
    chk("dual_first_pc", {115'd0, data[178:115]}, 179'h100);
    cycle();
    chk("dual_second_pc", {115'd0, data[178:115]}, 179'h104);
    cycle();

    // Lone port-1 commit and random rf encodings.
    for (int i = 0; i < 6; i++) begin
      rand_ports(); ack = 2'b10; cycle();
      rand_ports(); ack = 2'($urandom_range(0, 3)); cycle();
    end
    ack = 2'b00;
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) cycle();

    // Disabled capture: commits ignored, FIFO still drains.
    ready = 1'b0; ack = 2'b11; rand_ports(); cycle(); cycle();
    enable = 1'b0; rand_ports(); cycle(); cycle();
    ready = 1'b1; cycle(); cycle(); cycle();
    enable = 1'b1; ack = 2'b00; cycle();

    // Overflow: four dual commits fill, fifth drops two.
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rand_ports(); ack = 2'b11; cycle();
    end
    ack = 2'b00;
    chk("ovf_level", {175'd0, level}, 179'd8);
    chk("ovf_drop", {163'd0, drop}, 179'd2);
    cycle();
    ready = 1'b1;
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) cycle();
    rand_ports(); ack = 2'b01; cycle(); ack = 2'b00;
    chk("ovf_next_seq", {171'd0, data[7:0]}, 179'(m_seq - 8'd1));
    cycle();

    // Backpressure: ready toggles every cycle.
    for (int i = 0; i < 3; i++) begin
      rand_ports(); ack = 2'b11; ready = ~ready; cycle();
    end
    ack = 2'b00;
    for (int i = 0; i < 40 && sb_q.size() != 0; i++) begin
      ready = ~ready; cycle();
    end
    chk("bp_drained", {175'd0, level}, 179'd0);

    // Reset mid-stream with five buffered records.
    ready = 1'b0;
    rand_ports(); ack = 2'b11; cycle(); cycle();
    ack = 2'b01; cycle();
    ack = 2'b00;
    chk("pre_rst_level", {175'd0, level}, 179'd5);
    rst = 1'b1;
    #1;
    chk("async_rst_valid", {178'd0, valid}, 179'd0);
    chk("async_rst_level", {175'd0, level}, 179'd0);
    sb_q.delete(); m_seq = 8'd0; m_drop = 0;
    @(posedge clk); @(negedge clk);
    rst = 1'b0; ready = 1'b1;
    rand_ports(); ack = 2'b01; cycle(); ack = 2'b00;
    chk("post_rst_seq", {171'd0, data[7:0]}, 179'd0);
    cycle();

    // Drop counter saturation.
    ready = 1'b0; ack = 2'b11;
    for (int i = 0; i < 32780; i++) cycle();
    chk("sat_drop", {163'd0, drop}, 179'h0FFFF);
    cycle(); cycle();
    chk("sat_hold", {163'd0, drop}, 179'h0FFFF);
    ack = 2'b00; ready = 1'b1;
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
